// File: rtl/trivium_uart_pkg.sv
// Shared UART definitions for the Trivium host link (transmit and receive paths).
// Optional parity is selected per build with `TRIVIUM_UART_TX_PARITY_EN.
package trivium_uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 87;
    localparam int UART_DATA_W          = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    function automatic logic even_parity(input logic [UART_DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/trivium_uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each period.
// Holding i_clear keeps the counter at 0 so the first period after release is full length.
module trivium_uart_baud_gen #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    output logic o_bit_tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_bit_tick = (r_cnt == LAST) && !i_clear;

endmodule

// File: rtl/trivium_uart_tx.sv
// UART transmitter with a one-byte holding register feeding an LSB-first 8N1/8N2 serialiser.
// Define `TRIVIUM_UART_TX_PARITY_EN to insert an even-parity bit after data bit 7.
module trivium_uart_tx
    import trivium_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int STOP_BITS    = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [UART_DATA_W-1:0] tx_data,
    input  logic                   tx_valid,
    output logic                   tx_ready,
    output logic                   tx,
    output logic                   tx_busy,
    output logic                   tx_done
);

    uart_state_e            r_state;
    logic [UART_DATA_W-1:0] r_hold;
    logic                   r_hold_full;
    logic [UART_DATA_W-1:0] r_shift;
    logic [2:0]             r_bit_idx;
    logic                   r_stop_idx;
    logic                   r_tx;
    logic                   r_busy;
    logic                   r_done;
`ifdef TRIVIUM_UART_TX_PARITY_EN
    logic                   r_parity;
`endif

    logic w_tick;
    logic w_clear;
    logic w_accept;
    logic w_last_stop;
    logic w_load;

    assign w_clear     = (r_state == ST_IDLE);
    assign w_accept    = tx_valid && !r_hold_full;
    assign w_last_stop = (r_stop_idx == 1'(STOP_BITS - 1));
    // The held byte moves into the shifter either from idle or straight off the last stop bit.
    assign w_load      = r_hold_full &&
                         ((r_state == ST_IDLE) ||
                          (r_state == ST_STOP && w_tick && w_last_stop));

    trivium_uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_clear    (w_clear),
        .o_bit_tick (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_shift     <= '0;
            r_bit_idx   <= '0;
            r_stop_idx  <= 1'b0;
            r_tx        <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
`ifdef TRIVIUM_UART_TX_PARITY_EN
            r_parity    <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;

            if (w_accept) begin
                r_hold      <= tx_data;
                r_hold_full <= 1'b1;
            end else if (w_load) begin
                r_hold_full <= 1'b0;
            end

            if (w_load) begin
                r_shift <= r_hold;
`ifdef TRIVIUM_UART_TX_PARITY_EN
                r_parity <= even_parity(r_hold);
`endif
            end

            case (r_state)
                ST_IDLE: begin
                    if (r_hold_full) begin
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_tick) begin
                        r_tx      <= r_shift[0];
                        r_bit_idx <= '0;
                        r_state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        if (r_bit_idx == 3'd7) begin
`ifdef TRIVIUM_UART_TX_PARITY_EN
                            r_tx       <= r_parity;
                            r_state    <= ST_PARITY;
`else
                            r_tx       <= 1'b1;
                            r_stop_idx <= 1'b0;
                            r_state    <= ST_STOP;
`endif
                        end else begin
                            r_shift   <= r_shift >> 1;
                            r_tx      <= r_shift[1];
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end
                end
`ifdef TRIVIUM_UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (w_tick) begin
                        r_tx       <= 1'b1;
                        r_stop_idx <= 1'b0;
                        r_state    <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (w_tick) begin
                        if (w_last_stop) begin
                            r_done <= 1'b1;
                            if (r_hold_full) begin
                                r_tx    <= 1'b0;
                                r_state <= ST_START;
                            end else begin
                                r_tx    <= 1'b1;
                                r_busy  <= 1'b0;
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_stop_idx <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_ready = !r_hold_full;
    assign tx       = r_tx;
    assign tx_busy  = r_busy;
    assign tx_done  = r_done;

endmodule
